// File: rtl/ram_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_wr_pkg
// Description : Shared widths and lane types for the RAM write packer.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_wr_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int LANES      = DATA_W_DEF / 8;

    typedef logic [1:0]       lane_ptr_t;
    typedef logic [LANES-1:0] byte_mask_t;

endpackage : ram_wr_pkg
`default_nettype wire

// File: rtl/ram_wr_lane_acc.sv
`default_nettype none
// ============================================================================
// Module      : ram_wr_lane_acc
// Description : Byte accumulator, lane mask and lane pointer; flags a complete
//               word. Macro RAM_WR_PACKER_BIG_ENDIAN_EN reverses lane order.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_wr_lane_acc
    import ram_wr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs_i,
    input  logic              start_i,
    input  logic              last_i,
    input  logic [7:0]        din_i,
    output logic              word_done_o,
    output logic [DATA_W-1:0] word_o,
    output logic [DATA_W/8-1:0] mask_o,
    output logic              pending_o
);

    localparam int        NLANES    = DATA_W / 8;
    localparam lane_ptr_t LAST_LANE = lane_ptr_t'(NLANES - 1);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [NLANES-1:0] mask_q, mask_d;
    lane_ptr_t         ptr_q, ptr_d;

    lane_ptr_t         base_ptr;
    lane_ptr_t         lane;
    logic [DATA_W-1:0] merged_acc;
    logic [NLANES-1:0] merged_mask;
    logic              word_done;

    always_comb begin
        // A frame start discards whatever was buffered and restarts at lane 0.
        base_ptr    = start_i ? '0 : ptr_q;
        merged_acc  = start_i ? '0 : acc_q;
        merged_mask = start_i ? '0 : mask_q;
`ifdef RAM_WR_PACKER_BIG_ENDIAN_EN
        lane = LAST_LANE - base_ptr;
`else
        lane = base_ptr;
`endif
        merged_acc[8*lane +: 8] = din_i;
        merged_mask[lane]       = 1'b1;
        word_done = hs_i && (last_i || (base_ptr == LAST_LANE));

        acc_d  = acc_q;
        mask_d = mask_q;
        ptr_d  = ptr_q;
        if (hs_i) begin
            if (word_done) begin
                acc_d  = '0;
                mask_d = '0;
                ptr_d  = '0;
            end else begin
                acc_d  = merged_acc;
                mask_d = merged_mask;
                ptr_d  = base_ptr + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            mask_q <= '0;
            ptr_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            mask_q <= mask_d;
            ptr_q  <= ptr_d;
        end
    end

    assign word_done_o = word_done;
    assign word_o      = merged_acc;
    assign mask_o      = merged_mask;
    assign pending_o   = (ptr_q != '0);

endmodule : ram_wr_lane_acc
`default_nettype wire

// File: rtl/ram_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : ram_wr_packer
// Description : Packs a byte stream into RAM words and drives WA/WD/WEN/WClk_En.
//               Macro RAM_WR_PACKER_BIG_ENDIAN_EN selects big-endian lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_wr_packer
    import ram_wr_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                WClk,
    input  logic                Rst_n,
    input  logic                Frame_Start,
    input  logic [ADDR_W-1:0]   Start_Addr,
    input  logic [7:0]          Din,
    input  logic                Din_Valid,
    input  logic                Din_Last,
    output logic                Din_Ready,
    input  logic                Hold,
    output logic [ADDR_W-1:0]   WA,
    output logic [DATA_W-1:0]   WD,
    output logic [DATA_W/8-1:0] WEN,
    output logic                WClk_En,
    output logic [ADDR_W:0]     Word_Cnt,
    output logic                Wrap,
    output logic                Frame_Err
);

    localparam int              NLANES   = DATA_W / 8;
    localparam logic [ADDR_W:0] CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic                hs;
    logic                frame_hs;
    logic                word_done;
    logic                pending;
    logic [DATA_W-1:0]   word;
    logic [NLANES-1:0]   mask;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W:0]     base_cnt;

    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                wrap_q, wrap_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic [NLANES-1:0]   wen_q, wen_d;
    logic                en_q, en_d;

    assign Din_Ready = ~Hold;
    assign hs        = Din_Valid && Din_Ready;
    assign frame_hs  = hs && Frame_Start;

    ram_wr_lane_acc #(
        .DATA_W (DATA_W)
    ) u_lane_acc (
        .clk         (WClk),
        .rst_n       (Rst_n),
        .hs_i        (hs),
        .start_i     (Frame_Start),
        .last_i      (Din_Last),
        .din_i       (Din),
        .word_done_o (word_done),
        .word_o      (word),
        .mask_o      (mask),
        .pending_o   (pending)
    );

    // Frame-start values take effect in the same cycle so a 1-byte frame
    // lands at Start_Addr with a count of one.
    assign base_addr = frame_hs ? Start_Addr : addr_q;
    assign base_cnt  = frame_hs ? '0 : cnt_q;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        wrap_d = wrap_q;
        err_d  = err_q;
        wa_d   = wa_q;
        wd_d   = wd_q;
        wen_d  = wen_q;
        en_d   = 1'b0;
        if (frame_hs) begin
            addr_d = Start_Addr;
            cnt_d  = '0;
            wrap_d = 1'b0;
            if (pending) begin
                err_d = 1'b1;
            end
        end
        if (word_done) begin
            en_d   = 1'b1;
            wa_d   = base_addr;
            wd_d   = word;
            wen_d  = mask;
            addr_d = base_addr + 1'b1;
            if (base_addr == ADDR_MAX) begin
                wrap_d = 1'b1;
            end
            cnt_d = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + 1'b1;
        end
    end

    always_ff @(posedge WClk or negedge Rst_n) begin
        if (!Rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            wen_q  <= '0;
            en_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            wen_q  <= wen_d;
            en_q   <= en_d;
        end
    end

    assign WA        = wa_q;
    assign WD        = wd_q;
    assign WEN       = wen_q;
    assign WClk_En   = en_q;
    assign Word_Cnt  = cnt_q;
    assign Wrap      = wrap_q;
    assign Frame_Err = err_q;

endmodule : ram_wr_packer
`default_nettype wire

// File: tb/tb_ram_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_wr_packer
// Description : Self-checking bench: directed vector table, reset sequences and
//               randomized traffic against a byte-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_wr_packer;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fs = 1'b0;
    logic [8:0]  sa = '0;
    logic [7:0]  din = '0;
    logic        valid = 1'b0;
    logic        last = 1'b0;
    logic        hold = 1'b0;
    logic        ready;
    logic [8:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wen;
    logic        wen_en;
    logic [9:0]  cnt;
    logic        wrap;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_wr_packer dut (
        .WClk        (clk),
        .Rst_n       (rst_n),
        .Frame_Start (fs),
        .Start_Addr  (sa),
        .Din         (din),
        .Din_Valid   (valid),
        .Din_Last    (last),
        .Din_Ready   (ready),
        .Hold        (hold),
        .WA          (wa),
        .WD          (wd),
        .WEN         (wen),
        .WClk_En     (wen_en),
        .Word_Cnt    (cnt),
        .Wrap        (wrap),
        .Frame_Err   (err)
    );

    typedef struct {
        logic        fs;
        logic [8:0]  sa;
        logic [7:0]  din;
        logic        v, l, h;
        logic        en;
        logic [8:0]  wa;
        logic [31:0] wd;
        logic [3:0]  wen;
        logic [9:0]  cnt;
        logic        wrap, err;
    } vec_t;

    vec_t vt[$];

    // Reference model state: bytes of the word under construction.
    logic [7:0] m_bytes[$];
    int         m_addr, m_cnt;
    logic       m_wrap, m_err;
    logic [8:0] m_wa;
    logic [31:0] m_wd;
    logic [3:0] m_wen;

    function automatic logic [58:0] pack_dut();
        return {wen_en, wa, wd, wen, cnt, wrap, err, ready};
    endfunction

    task automatic check(input string name, input logic [58:0] act, input logic [58:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lane_of(input int i);
`ifdef RAM_WR_PACKER_BIG_ENDIAN_EN
        return 3 - i;
`else
        return i;
`endif
    endfunction

    // Table expectations are written little-endian; remap lanes for the other build.
    function automatic logic [31:0] fix_wd(input logic [31:0] w);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[8*lane_of(i) +: 8] = w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [3:0] fix_wen(input logic [3:0] m);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++) r[lane_of(i)] = m[i];
        return r;
    endfunction

    function automatic void add(input logic f, input logic [8:0] a, input logic [7:0] d,
                                input logic v, input logic l, input logic h, input logic en,
                                input logic [8:0] ewa, input logic [31:0] ewd, input logic [3:0] ewen,
                                input logic [9:0] ecnt, input logic ewrap, input logic eerr);
        vec_t x;
        x.fs = f; x.sa = a; x.din = d; x.v = v; x.l = l; x.h = h;
        x.en = en; x.wa = ewa; x.wd = ewd; x.wen = ewen; x.cnt = ecnt; x.wrap = ewrap; x.err = eerr;
        vt.push_back(x);
    endfunction

    function automatic void model_reset();
        m_bytes.delete();
        m_addr = 0; m_cnt = 0; m_wrap = 1'b0; m_err = 1'b0;
        m_wa = '0; m_wd = '0; m_wen = '0;
    endfunction

    task automatic step(input logic f, input logic [8:0] a, input logic [7:0] d,
                        input logic v, input logic l, input logic h);
        logic exp_en;
        @(negedge clk);
        fs = f; sa = a; din = d; valid = v; last = l; hold = h;
        exp_en = 1'b0;
        if (v && !h) begin
            if (f) begin
                if (m_bytes.size() != 0) m_err = 1'b1;
                m_bytes.delete();
                m_addr = a; m_cnt = 0; m_wrap = 1'b0;
            end
            m_bytes.push_back(d);
            if (m_bytes.size() == 4 || l) begin
                exp_en = 1'b1;
                m_wd = '0; m_wen = '0;
                foreach (m_bytes[i]) begin
                    m_wd[8*lane_of(i) +: 8] = m_bytes[i];
                    m_wen[lane_of(i)] = 1'b1;
                end
                m_wa = 9'(m_addr);
                if (m_addr == DEPTH - 1) m_wrap = 1'b1;
                m_addr = (m_addr + 1) % DEPTH;
                if (m_cnt < DEPTH) m_cnt++;
                m_bytes.delete();
            end
        end
        @(posedge clk); #1;
        check("model", pack_dut(), {exp_en, m_wa, m_wd, m_wen, 10'(m_cnt), m_wrap, m_err, ~h});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fs = 1'b0; valid = 1'b0; last = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        // Directed table: expected outputs are those visible just after each edge.
        add(1,9'h010,8'h11,1,0,0, 0,9'h000,32'h00000000,4'h0, 0,0,0);
        add(0,9'h000,8'h22,1,0,0, 0,9'h000,32'h00000000,4'h0, 0,0,0);
        add(0,9'h000,8'h33,1,0,0, 0,9'h000,32'h00000000,4'h0, 0,0,0);
        add(0,9'h000,8'h44,1,0,0, 1,9'h010,32'h44332211,4'hF, 1,0,0);
        add(0,9'h000,8'h55,1,0,0, 0,9'h010,32'h44332211,4'hF, 1,0,0);
        add(0,9'h000,8'h66,1,1,0, 1,9'h011,32'h00006655,4'h3, 2,0,0);
        add(0,9'h000,8'h00,0,0,0, 0,9'h011,32'h00006655,4'h3, 2,0,0);
        add(1,9'h030,8'hA1,1,0,0, 0,9'h011,32'h00006655,4'h3, 0,0,0);
        add(0,9'h000,8'hFF,1,0,1, 0,9'h011,32'h00006655,4'h3, 0,0,0);
        add(0,9'h000,8'hFE,1,1,1, 0,9'h011,32'h00006655,4'h3, 0,0,0);
        add(0,9'h000,8'hA2,1,0,0, 0,9'h011,32'h00006655,4'h3, 0,0,0);
        add(0,9'h000,8'hA3,1,0,0, 0,9'h011,32'h00006655,4'h3, 0,0,0);
        add(0,9'h000,8'hA4,1,0,0, 1,9'h030,32'hA4A3A2A1,4'hF, 1,0,0);
        add(1,9'h1FF,8'h01,1,0,0, 0,9'h030,32'hA4A3A2A1,4'hF, 0,0,0);
        add(0,9'h000,8'h02,1,0,0, 0,9'h030,32'hA4A3A2A1,4'hF, 0,0,0);
        add(0,9'h000,8'h03,1,0,0, 0,9'h030,32'hA4A3A2A1,4'hF, 0,0,0);
        add(0,9'h000,8'h04,1,0,0, 1,9'h1FF,32'h04030201,4'hF, 1,1,0);
        add(0,9'h000,8'h05,1,0,0, 0,9'h1FF,32'h04030201,4'hF, 1,1,0);
        add(0,9'h000,8'h06,1,0,0, 0,9'h1FF,32'h04030201,4'hF, 1,1,0);
        add(0,9'h000,8'h07,1,0,0, 0,9'h1FF,32'h04030201,4'hF, 1,1,0);
        add(0,9'h000,8'h08,1,0,0, 1,9'h000,32'h08070605,4'hF, 2,1,0);
        add(1,9'h040,8'hB1,1,0,0, 0,9'h000,32'h08070605,4'hF, 0,0,0);
        add(0,9'h000,8'hB2,1,0,0, 0,9'h000,32'h08070605,4'hF, 0,0,0);
        add(0,9'h000,8'hB3,1,0,0, 0,9'h000,32'h08070605,4'hF, 0,0,0);
        add(1,9'h020,8'hC1,1,0,0, 0,9'h000,32'h08070605,4'hF, 0,0,1);
        add(0,9'h000,8'hC2,1,0,0, 0,9'h000,32'h08070605,4'hF, 0,0,1);
        add(0,9'h000,8'hC3,1,0,0, 0,9'h000,32'h08070605,4'hF, 0,0,1);
        add(0,9'h000,8'hC4,1,0,0, 1,9'h020,32'hC4C3C2C1,4'hF, 1,0,1);
        add(1,9'h055,8'hAB,1,1,0, 1,9'h055,32'h000000AB,4'h1, 1,0,1);
        add(0,9'h000,8'h00,0,0,0, 0,9'h055,32'h000000AB,4'h1, 1,0,1);

        do_reset();
        #1;
        check("reset_state", pack_dut(), {1'b0, 9'h0, 32'h0, 4'h0, 10'h0, 1'b0, 1'b0, 1'b1});

        foreach (vt[i]) begin
            @(negedge clk);
            fs = vt[i].fs; sa = vt[i].sa; din = vt[i].din;
            valid = vt[i].v; last = vt[i].l; hold = vt[i].h;
            @(posedge clk); #1;
            check($sformatf("vec[%0d]", i), pack_dut(),
                  {vt[i].en, vt[i].wa, fix_wd(vt[i].wd), fix_wen(vt[i].wen), vt[i].cnt,
                   vt[i].wrap, vt[i].err, ~vt[i].h});
        end

        // Randomized traffic, biased so frames often start near the top of memory.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic       rv, rf, rl, rh;
            logic [8:0] ra;
            rv = ($urandom_range(0, 4) != 0);
            rf = ($urandom_range(0, 11) == 0);
            rl = ($urandom_range(0, 6) == 0);
            rh = ($urandom_range(0, 4) == 0);
            ra = ($urandom_range(0, 2) == 0) ? 9'(9'h1FC + $urandom_range(0, 3)) : 9'($urandom);
            step(rf, ra, 8'($urandom), rv, rl, rh);
        end

        // Long frame: count saturates at the RAM depth while the address wraps.
        step(1, 9'h000, 8'($urandom), 1, 0, 0);
        for (int c = 0; c < 2070; c++) step(0, 9'h000, 8'($urandom), 1, 0, 0);
        step(0, 9'h000, 8'h5A, 1, 1, 0);

        // Asynchronous reset with two bytes pending: nothing may be written.
        do_reset();
        step(1, 9'h077, 8'hD1, 1, 0, 0);
        step(0, 9'h000, 8'hD2, 1, 0, 0);
        @(negedge clk);
        valid = 1'b0; fs = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", pack_dut(), {1'b0, 9'h0, 32'h0, 4'h0, 10'h0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) step(0, 9'h000, 8'h00, 0, 0, 0);
        step(0, 9'h000, 8'hE1, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram_wr_packer
`default_nettype wire
